// File: rtl/logic_op_accumulator.sv
// Registered eight-function bitwise unit with direct and accumulate modes,
// status flags and a saturating count of accepted transactions.
module logic_op_accumulator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             acc_clear,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             flag_zero,
  output logic             flag_ones,
  output logic             flag_parity,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] x, y, alu;
  logic             accept;

  assign accept = ena & in_valid;

  // accumulate mode folds A into the shared result register
  assign x = mode ? result_q : in_a;
  assign y = mode ? in_a : in_b;

  always_comb begin
    alu = '0;
    unique case (op)
      3'd0: alu = x & y;
      3'd1: alu = x | y;
      3'd2: alu = x ^ y;
      3'd3: alu = ~(x & y);
      3'd4: alu = ~(x | y);
      3'd5: alu = ~(x ^ y);
      3'd6: alu = y;
      3'd7: alu = ~y;
      default: alu = '0;
    endcase
  end

  always_comb begin
    result_d = result_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      if (acc_clear) begin
        result_d = mode ? in_a : alu;
        cnt_d    = CNT_W'(1);
      end else begin
        result_d = alu;
        if (cnt_q != {CNT_W{1'b1}})
          cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (ena && acc_clear) begin
      result_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  assign result      = result_q;
  assign out_valid   = valid_q;
  assign op_count    = cnt_q;
  assign flag_zero   = ~|result_q;
  assign flag_ones   = &result_q;
  assign flag_parity = ^result_q;

endmodule

// File: doc/logic_op_accumulator.md
# logic_op_accumulator

Parametrised, registered bitwise logic unit: the next generation of the team's OR/AND selector. Selects one of eight bitwise operations per transaction, runs in direct mode (A op B) or accumulate mode (running acc op A), and provides registered result, valid strobe, status flags and a saturating operation counter. Instantiated inside the TinyTapeout top-level wrapper, which maps operands and control onto ui_in/uio_in and result/flags onto uo_out/uio_out.

## Interface
- WIDTH, 8, operand/result width in bits (>= 2)
- CNT_W, 8, width of the operation counter (>= 1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; low = freeze all state, accept nothing
- in_valid  in  1  operand/command valid
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored in accumulate mode)
- op  in  3  operation select, encoding below
- mode  in  1  0 = direct, 1 = accumulate
- acc_clear  in  1  synchronous clear/seed of accumulator and counter
- result  out  WIDTH  registered result / accumulator
- out_valid  out  1  one-cycle strobe: result updated by an accepted transaction
- flag_zero  out  1  result == 0
- flag_ones  out  1  result == all ones
- flag_parity  out  1  XOR-reduction of result
- op_count  out  CNT_W  accepted transactions since reset/clear, saturating

## Operation
- Accept = ena & in_valid, sampled on rising clk. All inputs sampled together.
- op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS (y), 7 NOT (~y).
- Direct mode (mode=0): x = in_a, y = in_b; result <= x op y. PASS gives in_b, NOT gives ~in_b.
- Accumulate mode (mode=1): x = result (current register), y = in_a; result <= x op y. PASS loads in_a, NOT loads ~in_a.
- Mode may change between transactions; the result register is shared, so a direct result becomes the seed for a following accumulate.
- acc_clear with ena=1 and no accept: result <= 0, op_count <= 0, out_valid <= 0.
- acc_clear with accept: result <= in_a (seed, op ignored) in accumulate mode, normal direct result in direct mode; op_count <= 1; out_valid <= 1.
- acc_clear with ena=0: ignored.
- op_count: +1 per accept; holds at 2^CNT_W-1 (no wrap).
- Flags: combinational from the result register only (never from inputs).
- ena=0: result and op_count hold; out_valid <= 0; in_valid/acc_clear ignored.

## Timing
- Latency: 1 cycle. Accept at edge N -> result, flags, op_count and out_valid=1 visible after edge N.
- out_valid high for exactly one cycle per accept; back-to-back accepts give continuous out_valid with a new result each cycle.
- Throughput: one transaction per cycle, no backpressure; no stall condition exists.
- Accumulate back-to-back: transaction N+1 uses result produced by transaction N (no bubble).
- Reset (rst_n low, any time, asynchronous): result=0, out_valid=0, op_count=0, hence flag_zero=1, flag_ones=0, flag_parity=0. Transaction in flight is discarded; first accept possible at the first rising edge with rst_n high.
- Outputs stable between accepts; no output depends combinationally on any input.

## Test plan
- Reset: assert rst_n=0 mid-accumulate with result=0xA5 -> immediately result=0x00, out_valid=0, op_count=0, flag_zero=1, flag_parity=0.
- Direct sweep (WIDTH=8): in_a=0xCC, in_b=0xAA, op 0..7 back-to-back -> results 0x88, 0xEE, 0x66, 0x77, 0x11, 0x99, 0xAA, 0x55, each one cycle after accept, out_valid high 8 consecutive cycles, op_count=8.
- Accumulate: acc_clear+accept mode=1 in_a=0xF0, then OR 0x0F, AND 0x3C, XOR 0xFF -> results 0xF0, 0xFF (flag_ones=1), 0x3C, 0xC3; flag_parity=0 on final.
- Enable gating: ena=0 with in_valid=1 and acc_clear=1 for 3 cycles -> result, op_count unchanged, out_valid=0; resume ena=1 -> next accept processed normally.
- Counter saturation (CNT_W=3): 10 consecutive accepts -> op_count reaches 7 and holds; acc_clear without accept -> op_count=0, result=0, out_valid=0.
- Mode switch: direct AND 0xF3,0x3F -> 0x33; then accumulate XNOR in_a=0x33 -> 0xFF, flag_ones=1.
